joy_port_bridge: RTL and testbench



---
 rtl/joy_port_bridge_pkg.sv | 16 +
 rtl/joy_pad_channel.sv | 115 +++++++++++
 rtl/joy_port_bridge.sv | 56 +++++
 tb/tb_joy_port_bridge.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/joy_port_bridge_pkg.sv
// Shared constants for the joypad front-end: button positions within a
// decoded report and the default report length.
package joy_port_bridge_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int DEFAULT_REPORT_BITS = 8;

endpackage

// File: rtl/joy_pad_channel.sv
// One controller port: input synchroniser, glitch filter, data latch toward
// the NES core, and a snoop of the serial read that produces a button report.
module joy_pad_channel
  import joy_port_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int REPORT_BITS = DEFAULT_REPORT_BITS,
  parameter bit INVERT      = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   strobe,
  input  logic                   pad_clock,
  input  logic                   pad_data,
  output logic                   nes_data,
  output logic [REPORT_BITS-1:0] report,
  output logic                   report_valid
);

  localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int CNT_W = $clog2(REPORT_BITS + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic                   clk_cur_q, clk_cur_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   held_q, held_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [REPORT_BITS-1:0] vec_q, vec_d;
  logic [REPORT_BITS-1:0] report_q, report_d;
  logic                   valid_q, valid_d;
  logic                   sync_out;
  logic                   clk_fall;
  logic                   clk_rise;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign clk_fall = clk_prev_q & ~clk_cur_q;
  assign clk_rise = ~clk_prev_q & clk_cur_q;

  // Next-state for synchroniser, filter, latch and the report shifter.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pad_data};
    filt_d     = filt_q;
    run_d      = '0;
    clk_cur_d  = pad_clock;
    clk_prev_d = clk_cur_q;
    held_d     = held_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    report_d   = report_q;
    valid_d    = 1'b0;

    if (sync_out != filt_q) begin
      if (run_q == RUN_W'(FILTER_LEN - 1)) begin
        filt_d = sync_out;
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end

    if (strobe || clk_fall) begin
      held_d = filt_q;
    end

    if (strobe) begin
      cnt_d = '0;
      vec_d = '0;
    end else if (clk_rise && (cnt_q < CNT_W'(REPORT_BITS))) begin
      for (int b = 0; b < REPORT_BITS; b++) begin
        if (cnt_q == CNT_W'(b)) begin
          vec_d[b] = ~held_q;
        end
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(REPORT_BITS - 1)) begin
        report_d = vec_d;
        valid_d  = 1'b1;
      end
    end
  end

  // State registers; idle pin level is high so everything released resets to 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= '1;
      filt_q     <= 1'b1;
      run_q      <= '0;
      clk_cur_q  <= 1'b0;
      clk_prev_q <= 1'b0;
      held_q     <= 1'b1;
      cnt_q      <= '0;
      vec_q      <= '0;
      report_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      filt_q     <= filt_d;
      run_q      <= run_d;
      clk_cur_q  <= clk_cur_d;
      clk_prev_q <= clk_prev_d;
      held_q     <= held_d;
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      report_q   <= report_d;
      valid_q    <= valid_d;
    end
  end

  assign nes_data     = INVERT ? ~held_q : held_q;
  assign report       = report_q;
  assign report_valid = valid_q;

endmodule

// File: rtl/joy_port_bridge.sv
// Joypad front-end between the serial pad pins and the NES core. Registers
// the shared strobe once and fans it out to one channel per pad.
module joy_port_bridge
  import joy_port_bridge_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int REPORT_BITS = DEFAULT_REPORT_BITS,
  parameter bit INVERT      = 1'b1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            joy_strobe,
  input  logic [NUM_PADS-1:0]             joy_clock,
  input  logic [NUM_PADS-1:0]             joy_data,
  output logic [NUM_PADS-1:0]             nes_joy_data,
  output logic [NUM_PADS*REPORT_BITS-1:0] pad_state,
  output logic [NUM_PADS-1:0]             report_valid
);

  logic strobe_q, strobe_d;

  // Strobe is sampled once here so all pads see the same registered level.
  always_comb begin
    strobe_d = joy_strobe;
  end

  // Registered strobe, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    joy_pad_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .REPORT_BITS (REPORT_BITS),
      .INVERT      (INVERT)
    ) u_channel (
      .clock        (clock),
      .reset        (reset),
      .strobe       (strobe_q),
      .pad_clock    (joy_clock[i]),
      .pad_data     (joy_data[i]),
      .nes_data     (nes_joy_data[i]),
      .report       (pad_state[i*REPORT_BITS +: REPORT_BITS]),
      .report_valid (report_valid[i])
    );
  end

endmodule

// File: tb/tb_joy_port_bridge.sv
// Directed bench for joy_port_bridge: a default two-pad inverting instance and
// a four-pad non-inverting instance share the same stimulus pins.
module tb_joy_port_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        joy_strobe;
  logic [3:0]  jclk;
  logic [3:0]  jdata;

  logic [1:0]  nes2;
  logic [15:0] ps2;
  logic [1:0]  rv2;
  logic [3:0]  nes4;
  logic [31:0] ps4;
  logic [3:0]  rv4;

  int total = 0;
  int bad   = 0;
  int rv2_cnt [2];
  int rv4_cnt [4];
  int base2   [2];
  int base4   [4];

  joy_port_bridge dut2 (
    .clock        (clock),
    .reset        (reset),
    .joy_strobe   (joy_strobe),
    .joy_clock    (jclk[1:0]),
    .joy_data     (jdata[1:0]),
    .nes_joy_data (nes2),
    .pad_state    (ps2),
    .report_valid (rv2)
  );

  joy_port_bridge #(
    .NUM_PADS (4),
    .INVERT   (1'b0)
  ) dut4 (
    .clock        (clock),
    .reset        (reset),
    .joy_strobe   (joy_strobe),
    .joy_clock    (jclk),
    .joy_data     (jdata),
    .nes_joy_data (nes4),
    .pad_state    (ps4),
    .report_valid (rv4)
  );

  always #5 clock = ~clock;

  // Count report_valid high cycles per pad, sampled mid-cycle.
  always @(negedge clock) begin
    for (int p = 0; p < 2; p++) if (rv2[p]) rv2_cnt[p] <= rv2_cnt[p] + 1;
    for (int p = 0; p < 4; p++) if (rv4[p]) rv4_cnt[p] <= rv4_cnt[p] + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snapshot();
    for (int p = 0; p < 2; p++) base2[p] = rv2_cnt[p];
    for (int p = 0; p < 4; p++) base4[p] = rv4_cnt[p];
  endtask

  // Plays a pad read on all four lines: lv holds pin levels, pad p bit k at lv[p*8+k].
  task automatic applyStimulus(input logic [31:0] lv, input int nclk);
    jdata      = {lv[24], lv[16], lv[8], lv[0]};
    joy_strobe = 1'b1;
    tick(6);
    joy_strobe = 1'b0;
    tick(2);
    for (int k = 0; k < nclk; k++) begin
      jclk = 4'hF;
      if (k + 1 < 8) jdata = {lv[25+k], lv[17+k], lv[9+k], lv[1+k]};
      else           jdata = 4'hF;
      tick(6);
      jclk = 4'h0;
      tick(6);
    end
    tick(4);
  endtask

  initial begin
    $display("[TB] start");
    reset      = 1'b1;
    joy_strobe = 1'b1;
    jclk       = 4'h0;
    jdata      = 4'h0;
    tick(3);
    checkOutput("rst_nes2", 32'(nes2), 32'h0);
    checkOutput("rst_ps2",  32'(ps2),  32'h0);
    checkOutput("rst_rv2",  32'(rv2),  32'h0);
    checkOutput("rst_nes4", 32'(nes4), 32'hF);
    checkOutput("rst_ps4",  ps4,       32'h0);

    reset = 1'b0;
    tick(5);
    checkOutput("first_sample_early", 32'(nes2), 32'h0);
    tick(1);
    checkOutput("first_sample_nes2", 32'(nes2), 32'h3);
    checkOutput("first_sample_nes4", 32'(nes4), 32'h0);

    $display("[TB] glitch rejection");
    jdata = 4'hF;
    tick(10);
    checkOutput("idle_high", 32'(nes2), 32'h0);
    jdata[0] = 1'b0;
    tick(2);
    jdata[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      checkOutput("glitch2", 32'(nes2[0]), 32'h0);
    end
    jdata[0] = 1'b0;
    tick(3);
    jdata[0] = 1'b1;
    tick(2);
    checkOutput("pulse3_before", 32'(nes2[0]), 32'h0);
    tick(1);
    checkOutput("pulse3_accept", 32'(nes2[0]), 32'h1);
    tick(3);
    checkOutput("pulse3_release", 32'(nes2[0]), 32'h0);

    $display("[TB] full report");
    snapshot();
    applyStimulus(32'hFFFF_FFF6, 8);
    checkOutput("full_ps2", 32'(ps2), 32'h0009);
    checkOutput("full_rv0", rv2_cnt[0] - base2[0], 32'd1);
    checkOutput("full_rv1", rv2_cnt[1] - base2[1], 32'd1);

    $display("[TB] aborted transaction");
    snapshot();
    applyStimulus(32'hFFFF_FF00, 5);
    checkOutput("abort_ps2", 32'(ps2), 32'h0009);
    checkOutput("abort_rv0", rv2_cnt[0] - base2[0], 32'd0);
    snapshot();
    applyStimulus(32'hFFFF_FF5A, 8);
    checkOutput("after_abort_ps2", 32'(ps2), 32'h00A5);
    checkOutput("after_abort_rv0", rv2_cnt[0] - base2[0], 32'd1);

    $display("[TB] extra clocks");
    snapshot();
    applyStimulus(32'hFFFF_FF3C, 10);
    checkOutput("extra_ps2", 32'(ps2), 32'h00C3);
    checkOutput("extra_rv0", rv2_cnt[0] - base2[0], 32'd1);

    $display("[TB] strobe with falling clock");
    jclk[0]  = 1'b1;
    jdata[0] = 1'b0;
    tick(8);
    checkOutput("hold_no_event", 32'(nes2[0]), 32'h0);
    joy_strobe = 1'b1;
    jclk[0]    = 1'b0;
    tick(1);
    checkOutput("simul_detect", 32'(nes2[0]), 32'h0);
    tick(1);
    checkOutput("simul_load", 32'(nes2[0]), 32'h1);
    checkOutput("simul_ps2", 32'(ps2), 32'h00C3);
    joy_strobe = 1'b0;
    jdata      = 4'hF;
    tick(10);

    $display("[TB] four pads");
    snapshot();
    applyStimulus(32'hFF00_7FFE, 8);
    checkOutput("quad_ps4", ps4, 32'h00FF_8001);
    checkOutput("quad_ps2", 32'(ps2), 32'h8001);
    for (int p = 0; p < 4; p++) begin
      checkOutput($sformatf("quad_rv%0d", p), rv4_cnt[p] - base4[p], 32'd1);
    end
    jdata      = 4'b0101;
    joy_strobe = 1'b1;
    tick(8);
    checkOutput("quad_nes4", 32'(nes4), 32'h5);
    checkOutput("quad_nes2", 32'(nes2), 32'h2);
    joy_strobe = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
